// File: rtl/z80_sys_pkg.sv
// Shared definitions for the Z80 system blocks: CPU clock mode encodings and divider defaults.
package z80_sys_pkg;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;
   localparam logic [1:0] MODE_HALT = 2'b10;

   localparam int SYS_DIV_DEFAULT = 5_000_000;

endpackage

// File: rtl/z80_clk_ctrl_if.sv
// Control/status bundle of the CPU clock controller; master = board/test side, slave = controller.
interface z80_clk_ctrl_if #(
   parameter int DIV_W = 26
);

   logic [1:0]       mode;
   logic             div_load;
   logic [DIV_W-1:0] div_value;
   logic             step_btn;
   logic             cpu_rst_req;
   logic             cpu_clk;
   logic             cpu_clk_rise;
   logic             cpu_nreset;
   logic             stepping;
   logic [15:0]      cycle_count;

   modport master (
      output mode, div_load, div_value, step_btn, cpu_rst_req,
      input  cpu_clk, cpu_clk_rise, cpu_nreset, stepping, cycle_count
   );

   modport slave (
      input  mode, div_load, div_value, step_btn, cpu_rst_req,
      output cpu_clk, cpu_clk_rise, cpu_nreset, stepping, cycle_count
   );

endinterface

// File: rtl/z80_clk_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a one-cycle rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_W = 16
) (
   input  logic mclk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic [1:0]            sync;
   logic                  stable;
   logic [DEBOUNCE_W-1:0] cnt;

   // A new level is accepted only after it has differed from the stable level for 2**DEBOUNCE_W samples.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         sync   <= 2'b00;
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         pulse <= 1'b0;
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (cnt == '1) begin
            stable <= sync[1];
            cnt    <= '0;
            pulse  <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/z80_clk_ctrl.sv
// CPU clock/reset controller: divides mclk into a 50% cpu_clk, sequences nRESET, and supports run/step/halt.
module z80_clk_ctrl
   import z80_sys_pkg::*;
#(
   parameter int DIV_W        = 26,
   parameter int DIV_DEFAULT  = SYS_DIV_DEFAULT,
   parameter int RESET_CYCLES = 4,
   parameter int DEBOUNCE_W   = 16
) (
   input  logic           mclk,
   input  logic           rst,
   z80_clk_ctrl_if.slave  bus
);

   localparam int RC_W = $clog2(RESET_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_HIGH    = 2'd2;

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] counter;
   logic             tick;
   logic             clk_en;
   logic             rise_ev;
   logic             fall_ev;
   logic             step_pulse;
   logic             rst_active;
   logic [RC_W-1:0]  rst_cnt;
   logic [1:0]       step_state;
   logic             cpu_clk_q;
   logic             cpu_clk_rise_q;
   logic             cpu_nreset_q;
   logic             stepping_q;
   logic [15:0]      cycle_count_q;

   btn_debounce #(
      .DEBOUNCE_W (DEBOUNCE_W)
   ) u_step_btn (
      .mclk  (mclk),
      .rst   (rst),
      .btn   (bus.step_btn),
      .pulse (step_pulse)
   );

   // Terminal test uses >= so a divisor shrunk below the running count ends the half-period at once.
   assign tick = (counter >= div_reg);

   always_comb begin
      clk_en = rst_active
            || (bus.mode == MODE_RUN)
            || ((bus.mode == MODE_STEP) && (step_state == ST_PENDING));
   end

   assign rise_ev = tick && !cpu_clk_q && clk_en;
   assign fall_ev = tick && cpu_clk_q;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         div_reg <= DIV_W'(DIV_DEFAULT);
         counter <= '0;
      end else begin
         if (bus.div_load) begin
            div_reg <= bus.div_value;
         end
         counter <= tick ? '0 : counter + 1'b1;
      end
   end

   // The high phase always completes; only the low-to-high transition is gated.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         cpu_clk_q      <= 1'b0;
         cpu_clk_rise_q <= 1'b0;
         cycle_count_q  <= 16'd0;
      end else begin
         cpu_clk_rise_q <= rise_ev;
         if (fall_ev) begin
            cpu_clk_q <= 1'b0;
         end else if (rise_ev) begin
            cpu_clk_q     <= 1'b1;
            cycle_count_q <= cycle_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         rst_active   <= 1'b1;
         rst_cnt      <= '0;
         cpu_nreset_q <= 1'b0;
      end else if (bus.cpu_rst_req) begin
         rst_active   <= 1'b1;
         rst_cnt      <= '0;
         cpu_nreset_q <= 1'b0;
      end else if (rst_active) begin
         if (rise_ev && (rst_cnt != RC_LAST)) begin
            rst_cnt <= rst_cnt + 1'b1;
         end
         if (fall_ev && (rst_cnt == RC_LAST)) begin
            rst_active   <= 1'b0;
            cpu_nreset_q <= 1'b1;
         end
      end
   end

   // Step FSM: a pending step is only accepted from idle, so button edges mid-step are ignored.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         step_state <= ST_IDLE;
         stepping_q <= 1'b0;
      end else begin
         case (step_state)
            ST_IDLE: begin
               if (step_pulse && (bus.mode == MODE_STEP) && !rst_active && !bus.cpu_rst_req) begin
                  step_state <= ST_PENDING;
                  stepping_q <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (bus.cpu_rst_req || (bus.mode != MODE_STEP)) begin
                  step_state <= ST_IDLE;
                  stepping_q <= 1'b0;
               end else if (rise_ev) begin
                  step_state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (fall_ev) begin
                  step_state <= ST_IDLE;
                  stepping_q <= 1'b0;
               end
            end
            default: begin
               step_state <= ST_IDLE;
               stepping_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_clk      = cpu_clk_q;
   assign bus.cpu_clk_rise = cpu_clk_rise_q;
   assign bus.cpu_nreset   = cpu_nreset_q;
   assign bus.stepping     = stepping_q;
   assign bus.cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_z80_clk_ctrl.sv
// Self-checking bench for z80_clk_ctrl with small divider/debounce parameters.
module tb_z80_clk_ctrl;
   import z80_sys_pkg::*;

   localparam int DIV_W   = 26;
   localparam int DIV_DEF = 3;
   localparam int RST_CYC = 4;
   localparam int DEB_W   = 3;

   logic mclk = 1'b0;
   logic rst;

   z80_clk_ctrl_if #(.DIV_W(DIV_W)) bus ();

   z80_clk_ctrl #(
      .DIV_W        (DIV_W),
      .DIV_DEFAULT  (DIV_DEF),
      .RESET_CYCLES (RST_CYC),
      .DEBOUNCE_W   (DEB_W)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      string name;
      int    exp;
   } sb_t;

   typedef struct {
      logic [DIV_W-1:0] div;
      int               exp_hi;
      int               exp_lo;
   } div_vec_t;

   sb_t      sb[$];
   div_vec_t vecs[4];
   int       total = 0;
   int       bad = 0;
   int       clk_rises = 0;
   int       pulse_err = 0;
   logic     prev_clk = 1'b0;
   logic     last_clk = 1'b0;
   logic     prev_step = 1'b0;
   logic     last_step = 1'b0;

   function void expect_val(string name, int exp);
      sb.push_back('{name, exp});
   endfunction

   function void check_output(int act);
      sb_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty actual=%0d", act);
      end else begin
         e = sb.pop_front();
         if (act != e.exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", e.name, act, e.exp);
         end
      end
   endfunction

   task automatic sample();
      @(negedge mclk);
      prev_clk  = last_clk;
      last_clk  = bus.cpu_clk;
      prev_step = last_step;
      last_step = bus.stepping;
      if (last_clk && !prev_clk) clk_rises++;
      if (bus.cpu_clk_rise !== (last_clk && !prev_clk)) pulse_err++;
   endtask

   task automatic wait_level(input logic lvl, input int limit, output int n);
      n = 0;
      while (last_clk !== lvl) begin
         if (n >= limit) begin
            n = -1;
            return;
         end
         sample();
         n++;
      end
   endtask

   task automatic measure_half(output int hi, output int lo);
      int n;
      hi = -1;
      lo = -1;
      wait_level(1'b0, 100, n);
      if (n < 0) return;
      wait_level(1'b1, 100, n);
      if (n < 0) return;
      hi = 0;
      while (last_clk == 1'b1 && hi < 100) begin
         hi++;
         sample();
      end
      lo = 0;
      while (last_clk == 1'b0 && lo < 100) begin
         lo++;
         sample();
      end
   endtask

   task automatic apply_div(input logic [DIV_W-1:0] v);
      bus.div_value = v;
      bus.div_load  = 1'b1;
      sample();
      bus.div_load  = 1'b0;
   endtask

   task automatic apply_rst_req();
      bus.cpu_rst_req = 1'b1;
      sample();
      bus.cpu_rst_req = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      expect_val({tag, "_cpu_clk"}, 0);      check_output(int'(bus.cpu_clk));
      expect_val({tag, "_cpu_clk_rise"}, 0); check_output(int'(bus.cpu_clk_rise));
      expect_val({tag, "_cpu_nreset"}, 0);   check_output(int'(bus.cpu_nreset));
      expect_val({tag, "_stepping"}, 0);     check_output(int'(bus.stepping));
      expect_val({tag, "_cycle_count"}, 0);  check_output(int'(bus.cycle_count));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, h, l, r0, c0, saw, fall_ok, toggles, found;

      vecs[0] = '{div: 26'd5, exp_hi: 6, exp_lo: 6};
      vecs[1] = '{div: 26'd0, exp_hi: 1, exp_lo: 1};
      vecs[2] = '{div: 26'd1, exp_hi: 2, exp_lo: 2};
      vecs[3] = '{div: 26'd3, exp_hi: 4, exp_lo: 4};

      rst             = 1'b1;
      bus.mode        = MODE_RUN;
      bus.div_load    = 1'b0;
      bus.div_value   = '0;
      bus.step_btn    = 1'b0;
      bus.cpu_rst_req = 1'b0;
      sample();
      sample();
      check_reset_outputs("reset");

      // Power-on sequence in RUN
      clk_rises = 0;
      rst = 1'b0;
      expect_val("first_rise_latency", DIV_DEF + 1);
      wait_level(1'b1, 100, n);
      check_output(n);
      n = 0;
      while (bus.cpu_nreset !== 1'b1 && n < 300) begin
         sample();
         n++;
      end
      expect_val("nreset_timeout", 0);          check_output(int'(n >= 300));
      expect_val("nreset_rises", RST_CYC);      check_output(clk_rises);
      expect_val("nreset_on_fall", 1);          check_output(int'(prev_clk && !last_clk));
      expect_val("nreset_cycle_count", RST_CYC); check_output(int'(bus.cycle_count));
      expect_val("run_high", DIV_DEF + 1);
      expect_val("run_low", DIV_DEF + 1);
      measure_half(h, l);
      check_output(h);
      check_output(l);

      // HALT requested during the high phase
      wait_level(1'b0, 100, n);
      wait_level(1'b1, 100, n);
      bus.mode = MODE_HALT;
      expect_val("halt_high_len", DIV_DEF + 1);
      h = 0;
      while (last_clk == 1'b1 && h < 100) begin
         h++;
         sample();
      end
      check_output(h);
      r0 = clk_rises;
      c0 = int'(bus.cycle_count);
      repeat (40) sample();
      expect_val("halt_rises", 0);       check_output(clk_rises - r0);
      expect_val("halt_count_delta", 0); check_output(int'(bus.cycle_count) - c0);
      expect_val("halt_clk_low", 0);     check_output(int'(last_clk));

      // STEP: short bounce, then a proper press
      bus.mode = MODE_STEP;
      repeat (5) sample();
      r0 = clk_rises;
      saw = 0;
      bus.step_btn = 1'b1;
      repeat (5) sample();
      bus.step_btn = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sample();
         if (last_step) saw = 1;
      end
      expect_val("bounce_rises", 0);    check_output(clk_rises - r0);
      expect_val("bounce_stepping", 0); check_output(saw);

      r0 = clk_rises;
      c0 = int'(bus.cycle_count);
      saw = 0;
      fall_ok = -1;
      bus.step_btn = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i == 20) bus.step_btn = 1'b0;
         sample();
         if (last_step) saw = 1;
         if (prev_clk && !last_clk) fall_ok = int'(prev_step && !last_step);
      end
      expect_val("step_rises", 1);        check_output(clk_rises - r0);
      expect_val("step_count_delta", 1);  check_output(int'(bus.cycle_count) - c0);
      expect_val("step_seen", 1);         check_output(saw);
      expect_val("step_clear_on_fall", 1); check_output(fall_ok);
      expect_val("step_final", 0);        check_output(int'(bus.stepping));

      // Divisor reload table
      bus.mode = MODE_RUN;
      foreach (vecs[i]) begin
         expect_val($sformatf("div%0d_high", vecs[i].div), vecs[i].exp_hi);
         expect_val($sformatf("div%0d_low", vecs[i].div), vecs[i].exp_lo);
         apply_div(vecs[i].div);
         measure_half(h, l);
         measure_half(h, l);
         check_output(h);
         check_output(l);
      end

      // Shrinking the divisor mid high phase
      wait_level(1'b0, 100, n);
      wait_level(1'b1, 100, n);
      sample();
      apply_div('0);
      n = 0;
      while (last_clk == 1'b1 && n < 10) begin
         sample();
         n++;
      end
      expect_val("shrink_within_old_half", 1);
      check_output(int'(n >= 1 && n <= DIV_DEF + 1));
      toggles = 0;
      for (int i = 0; i < 8; i++) begin
         sample();
         if (last_clk != prev_clk) toggles++;
      end
      expect_val("shrink_toggle_every_cycle", 8);
      check_output(toggles);
      apply_div(26'(DIV_DEF));

      // Reset requests: mid-run, then mid-sequence under HALT
      wait_level(1'b0, 100, n);
      wait_level(1'b1, 100, n);
      sample();
      apply_rst_req();
      expect_val("req1_nreset_low", 0); check_output(int'(bus.cpu_nreset));
      r0 = clk_rises;
      n = 0;
      while (clk_rises < r0 + 2 && n < 100) begin
         sample();
         n++;
      end
      bus.mode = MODE_HALT;
      wait_level(1'b0, 100, n);
      wait_level(1'b1, 100, n);
      sample();
      sample();
      r0 = clk_rises;
      apply_rst_req();
      expect_val("req2_nreset_low", 0); check_output(int'(bus.cpu_nreset));
      n = 0;
      while (bus.cpu_nreset !== 1'b1 && n < 300) begin
         sample();
         n++;
      end
      expect_val("req2_timeout", 0);       check_output(int'(n >= 300));
      expect_val("req2_rises", RST_CYC);   check_output(clk_rises - r0);
      expect_val("req2_on_fall", 1);       check_output(int'(prev_clk && !last_clk));
      r0 = clk_rises;
      repeat (30) sample();
      expect_val("req2_halt_after", 0);    check_output(clk_rises - r0);

      // Async reset while stepping in the high phase
      bus.mode = MODE_STEP;
      bus.step_btn = 1'b1;
      found = 0;
      for (int i = 0; i < 60; i++) begin
         sample();
         if (last_clk && bus.stepping) begin
            found = 1;
            break;
         end
      end
      expect_val("async_setup_found", 1); check_output(found);
      #1 rst = 1'b1;
      #1 check_reset_outputs("async");
      bus.step_btn = 1'b0;
      sample();
      sample();
      rst = 1'b0;
      sample();

      expect_val("rise_pulse_alignment_errors", 0);
      check_output(pulse_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
